div8by4_seq: RTL

//   Sequential restoring divider, the inverse of the 4x4 array multiplier: takes an
//   8-bit dividend (e.g. a product m7..m0) and a 4-bit divisor, returns quotient and

---
 rtl/div8by4_seq_if.sv | 26 ++
 rtl/div8by4_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/div8by4_seq_if.sv
// Start/busy/done handshake bundle for the sequential 8-by-4 divider.
// The master drives the operands and start; the slave returns the results and status.
interface div8by4_seq_if #(
   parameter int DW = 8,
   parameter int VW = 4
);
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          q_ovf;
   logic          dbz;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, q_ovf, dbz
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, q_ovf, dbz
   );
endinterface

// File: rtl/div8by4_seq.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Results are registered and change only at completion, on divide-by-zero, or on reset.
module div8by4_seq #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input logic          clk,
   input logic          reset,
   div8by4_seq_if.slave bus
);
   localparam int            CW       = $clog2(DW);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DZ   = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [DW-1:0] dvd_r, dvd_s;
   logic [VW-1:0] dvs_r, dvs_s;
   logic [VW:0]   prem_r, prem_s;
   logic [DW-1:0] q_r, q_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [DW-1:0] quotient_r, quotient_s;
   logic [VW-1:0] remainder_r, remainder_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;
   logic          q_ovf_r, q_ovf_s;
   logic          dbz_r, dbz_s;

   logic [VW:0]   r_shift_s;
   logic [VW:0]   r_sub_s;
   logic          ge_s;
   logic [DW-1:0] q_shift_s;

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         dvd_r       <= {DW{1'b0}};
         dvs_r       <= {VW{1'b0}};
         prem_r      <= {(VW + 1){1'b0}};
         q_r         <= {DW{1'b0}};
         cnt_r       <= {CW{1'b0}};
         quotient_r  <= {DW{1'b0}};
         remainder_r <= {VW{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         q_ovf_r     <= 1'b0;
         dbz_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         dvd_r       <= dvd_s;
         dvs_r       <= dvs_s;
         prem_r      <= prem_s;
         q_r         <= q_s;
         cnt_r       <= cnt_s;
         quotient_r  <= quotient_s;
         remainder_r <= remainder_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         q_ovf_r     <= q_ovf_s;
         dbz_r       <= dbz_s;
      end
   end

   // Next-state and next-datapath logic; one restoring step per CALC cycle
   always_comb begin
      state_s     = state_r;
      dvd_s       = dvd_r;
      dvs_s       = dvs_r;
      prem_s      = prem_r;
      q_s         = q_r;
      cnt_s       = cnt_r;
      quotient_s  = quotient_r;
      remainder_s = remainder_r;
      busy_s      = busy_r;
      done_s      = 1'b0;
      q_ovf_s     = q_ovf_r;
      dbz_s       = dbz_r;

      // Partial remainder stays below 2*divisor, so the VW+1-bit subtract never wraps
      r_shift_s = {prem_r[VW-1:0], dvd_r[DW-1]};
      ge_s      = (r_shift_s >= {1'b0, dvs_r});
      if (ge_s) begin
         r_sub_s = r_shift_s - {1'b0, dvs_r};
      end else begin
         r_sub_s = r_shift_s;
      end
      q_shift_s = {q_r[DW-2:0], ge_s};

      case (state_r)
         IDLE: begin
            if (bus.start) begin
               dvd_s  = bus.dividend;
               dvs_s  = bus.divisor;
               prem_s = {(VW + 1){1'b0}};
               q_s    = {DW{1'b0}};
               cnt_s  = {CW{1'b0}};
               busy_s = 1'b1;
               if (bus.divisor == {VW{1'b0}}) begin
                  state_s = DZ;
               end else begin
                  state_s = CALC;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            dvd_s  = {dvd_r[DW-2:0], 1'b0};
            prem_s = r_sub_s;
            q_s    = q_shift_s;
            cnt_s  = cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
               state_s     = IDLE;
               busy_s      = 1'b0;
               done_s      = 1'b1;
               quotient_s  = q_shift_s;
               remainder_s = r_sub_s[VW-1:0];
               q_ovf_s     = |q_shift_s[DW-1:VW];
               dbz_s       = 1'b0;
            end else begin
               state_s = CALC;
            end
         end
         DZ: begin
            state_s     = IDLE;
            busy_s      = 1'b0;
            done_s      = 1'b1;
            quotient_s  = {DW{1'b1}};
            remainder_s = {VW{1'b0}};
            q_ovf_s     = 1'b0;
            dbz_s       = 1'b1;
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
   assign bus.q_ovf     = q_ovf_r;
   assign bus.dbz       = dbz_r;
endmodule
